// File: rtl/tile_pixel_shifter.sv
// Multi-plane tile-row pixel shifter with a staging buffer, bubble-free reload,
// fine-scroll discard and sticky underflow. Define TILE_SHIFTER_HFLIP_EN to honour hflip.
module tile_pixel_shifter #(
  parameter int WIDTH  = 8,
  parameter int PLANES = 2,
  parameter int CNTW   = $clog2(WIDTH + 1)
) (
  input  logic              clkpipe,
  input  logic              nreset,
  input  logic [WIDTH-1:0]  md,
  input  logic [PLANES-1:0] plane_we,
  input  logic              hflip,
  input  logic              stage_commit,
  input  logic              start,
  input  logic [CNTW-1:0]   fine_x,
  input  logic              shift_en,
  output logic [PLANES-1:0] pix,
  output logic              pix_valid,
  output logic              stg_full,
  output logic              underflow
);

  logic [WIDTH-1:0] stg [PLANES];
  logic [WIDTH-1:0] sh  [PLANES];
  logic             stg_flip;
  logic             stg_full_q;
  logic [CNTW-1:0]  cnt;
  logic [CNTW-1:0]  disc;
  logic             underflow_q;

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // Reload on the edge that would consume the last old pixel, so rows abut.
  logic reload;
  logic shifting;
  logic stage_open;
  assign reload     = stg_full_q && ((cnt == '0) || ((cnt == CNTW'(1)) && shift_en));
  assign shifting   = shift_en && (cnt != '0);
  assign stage_open = !stg_full_q || reload;

`ifndef TILE_SHIFTER_HFLIP_EN
  logic unused_hflip;
  assign unused_hflip = hflip;
  assign stg_flip     = 1'b0;
`endif

  always_ff @(posedge clkpipe or negedge nreset) begin
    if (!nreset) begin
      for (int p = 0; p < PLANES; p++) begin
        stg[p] <= '0;
        sh[p]  <= '0;
      end
`ifdef TILE_SHIFTER_HFLIP_EN
      stg_flip <= 1'b0;
`endif
      stg_full_q  <= 1'b0;
      cnt         <= '0;
      disc        <= '0;
      underflow_q <= 1'b0;
    end else if (start) begin
      for (int p = 0; p < PLANES; p++) sh[p] <= '0;
      cnt         <= '0;
      stg_full_q  <= 1'b0;
      underflow_q <= 1'b0;
      disc        <= fine_x;
    end else begin
      if (reload) begin
        for (int p = 0; p < PLANES; p++)
          sh[p] <= stg_flip ? bit_reverse(stg[p]) : stg[p];
        cnt        <= CNTW'(WIDTH);
        stg_full_q <= 1'b0;
      end else if (shifting) begin
        for (int p = 0; p < PLANES; p++)
          sh[p] <= {sh[p][WIDTH-2:0], 1'b0};
        cnt <= cnt - CNTW'(1);
      end else if (shift_en) begin
        underflow_q <= 1'b1;
      end

      if (shifting && (disc != '0)) disc <= disc - CNTW'(1);

      // A commit on the consuming edge lands after the reload took the old row.
      if (stage_open) begin
        for (int p = 0; p < PLANES; p++)
          if (plane_we[p]) stg[p] <= md;
        if (stage_commit) begin
          stg_full_q <= 1'b1;
`ifdef TILE_SHIFTER_HFLIP_EN
          stg_flip   <= hflip;
`endif
        end
      end
    end
  end

  for (genvar p = 0; p < PLANES; p++) begin : g_pix
    assign pix[p] = sh[p][WIDTH-1];
  end

  assign pix_valid = (cnt != '0) && (disc == '0);
  assign stg_full  = stg_full_q;
  assign underflow = underflow_q;

endmodule

// File: doc/tile_pixel_shifter.md
# tile_pixel_shifter

Parametrised tile-row pixel shifter for the PPU pixel pipe: a multi-plane successor to the 2-plane background shifter. Fetcher writes plane bytes into a staging buffer. Staged rows reload into the shift registers back-to-back without a bubble. One pixel per plane is emitted per shift. Adds horizontal flip, fine-scroll discard, occupancy counting and sticky underflow detection.

## Interface
- WIDTH, 8, pixels per tile row (bits per plane byte)
- PLANES, 2, number of bitplanes (colour index width)
- CNTW, $clog2(WIDTH+1), width of pixel counter
- clkpipe  in  1  pixel-pipe clock, all state on rising edge
- nreset  in  1  asynchronous active-low reset
- md  in  WIDTH  tile data bus from VRAM
- plane_we  in  PLANES  bit p captures md into staging plane p
- hflip  in  1  flip attribute, sampled with stage_commit
- stage_commit  in  1  marks staging row complete
- start  in  1  line start: flush and arm discard
- fine_x  in  CNTW  pixels to discard after start (0..WIDTH-1)
- shift_en  in  1  advance one pixel
- pix  out  PLANES  current pixel, bit p = MSB of plane p shifter
- pix_valid  out  1  pix is a displayable pixel
- stg_full  out  1  staging row held, not yet consumed
- underflow  out  1  sticky: shift_en with empty shifter

## Operation
- State: stg[PLANES][WIDTH], stg_flip, stg_full, sh[PLANES][WIDTH], cnt (CNTW), disc (CNTW), underflow.
- Priority per edge: start > reload/shift > staging write.
- start: sh=0, cnt=0, stg_full=0, underflow=0, disc=fine_x; all other inputs ignored that cycle.
- Staging write: plane_we[p] writes stg[p]=md; stage_commit sets stg_full=1 and stg_flip=hflip. Ignored while stg_full=1, unless the same edge consumes staging. In that case the reload uses the old contents and the new write lands.
- Shift: shift_en && cnt!=0 → each sh[p] shifts left one bit with a 0 fill, and cnt decrements. If disc!=0, disc decrements.
- Reload: when stg_full && (cnt==0 || (cnt==1 && shift_en)):
  - sh[p] = stg[p], bit-reversed if stg_flip.
  - cnt = WIDTH; stg_full = 0.
  - Reload replaces that edge's shift result, so the final old pixel is emitted and the first new pixel follows with no gap.
- Underflow: shift_en && cnt==0 && !reload → underflow=1 (sticky until start or reset). Nothing else changes.
- pix = {sh[PLANES-1][WIDTH-1], ..., sh[0][WIDTH-1]}, combinational from registers.
- pix_valid = (cnt!=0) && (disc==0).
- Shifts while disc!=0 consume pixels without display.

## Timing
- Reset (async assert, sync-safe deassert): sh=0, stg=0, cnt=0, disc=0, stg_full=0, stg_flip=0, underflow=0. Outputs: pix=0, pix_valid=0, stg_full=0, underflow=0.
- Commit at edge N → stg_full=1 after N. With an empty shifter, reload happens at edge N+1 and pix_valid=1 after N+1 (unless disc!=0).
- Steady-state throughput: one pixel per clkpipe with shift_en held. The fetcher must commit within WIDTH-1 shifts of the previous reload to avoid underflow.
- Mid-line start: flushes immediately; a staged row is discarded.
- Reset mid-row: all state cleared, no partial output.

## Configuration
- TILE_SHIFTER_HFLIP_EN defined: stg_flip sampled from hflip; reload bit-reverses flipped rows.
- Undefined: stg_flip tied 0 and hflip is ignored (port retained). Rows always load MSB-first.

## Test plan
- Reset then idle with shift_en=1: pix=0, pix_valid=0, underflow=1 after first shift.
- WIDTH=8, PLANES=2, plane0=0xA5, plane1=0x3C, commit, hflip=0, then 8 shifts: pix = 1,0,1,0,0,1,0,1 on plane0 and 0,0,1,1,1,1,0,0 on plane1. pix_valid=1 for exactly 8 cycles.
- Same data with hflip=1 under TILE_SHIFTER_HFLIP_EN: plane0 sequence reversed (1,0,1,0,0,1,0,1 for 0xA5 is palindromic, so use 0x80). 0x80 flipped gives a 1 on the 8th pixel only; without the macro it gives a 1 on the 1st pixel.
- Back-to-back rows 0xFF then 0x00 with the second commit at shift 4: 16 consecutive valid pixels, no gap, stg_full drops on the reload edge, underflow=0.
- start with fine_x=3, row 0xF0, 8 shifts: first 3 shifts give pix_valid=0; then pixels 1,0,0,0,0 are valid.
- Commit while stg_full=1 and cnt=5: second row dropped and first row unchanged. Then start mid-row: cnt=0, stg_full=0, underflow cleared.
